tracker_row_sequencer: RTL and testbench

- Pattern-playback controller driving the DDS sine voice.
- Holds a small pattern of row entries, steps through them at a tempo set by a tick prescaler and a per-row tick count.
- Drives freq_word, the note gate, and a one-cycle phase-accumulator retrigger into the DDS voice.
- Sits between the CPU/config logic and one DDS_Sine instance.

---
 rtl/tracker_seq_pkg.sv | 19 +
 rtl/tracker_tick_div.sv | 31 +++
 rtl/tracker_row_sequencer.sv | 178 +++++++++++++++++
 tb/tb_tracker_row_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_seq_pkg.sv
// Shared types for the tracker row sequencer: pattern commands, FSM states, field widths.
package tracker_seq_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [1:0] {
    REST = 2'b00,
    NOTE = 2'b01,
    HOLD = 2'b10,
    END  = 2'b11
  } seq_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    PLAY  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/tracker_tick_div.sv
// Tempo prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle as a tick.
module tracker_tick_div
  import tracker_seq_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_active_high,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = en && !clr && w_wrap;

  always_ff @(posedge clk) begin
    if (rst_active_high || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tracker_row_sequencer.sv
// Pattern-playback controller feeding one DDS sine voice with freq_word, gate and retrigger.
// Optional portamento (glide toward each new note) is built when TRACKER_SEQ_PORTA_EN is defined.
module tracker_row_sequencer
  import tracker_seq_pkg::*;
#(
  parameter int PHASE_WIDTH = 10,
  parameter int ROWS        = 16,
  parameter int TICK_DIV    = 100000,
  parameter int PORTA_STEP  = 4
) (
  input  logic                        clk,
  input  logic                        rst_active_high,
  input  logic                        start,
  input  logic                        stop,
  input  logic [3:0]                  speed,
  input  logic                        cfg_wr_en,
  input  logic [$clog2(ROWS)-1:0]     cfg_wr_addr,
  input  logic [PHASE_WIDTH+1:0]      cfg_wr_data,
  output logic                        cfg_wr_ready,
  output logic [PHASE_WIDTH-1:0]      freq_word,
  output logic                        gate,
  output logic                        dds_retrig,
  output logic [$clog2(ROWS)-1:0]     row_idx,
  output logic                        row_strobe,
  output logic                        playing
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int ENT_W = PHASE_WIDTH + CMD_W;

  if (ROWS < 2 || (ROWS & (ROWS - 1)) != 0) begin : g_bad_rows
    $error("ROWS must be a power of 2 and at least 2");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (PORTA_STEP < 1) begin : g_bad_step
    $error("PORTA_STEP must be at least 1");
  end

  logic [ENT_W-1:0]       r_pattern [ROWS];
  seq_state_e             r_state;
  logic [PHASE_WIDTH-1:0] r_freq;
  logic                   r_gate;
  logic                   r_retrig;
  logic                   r_strobe;
  logic [ROW_W-1:0]       r_row_idx;
  logic [3:0]             r_ticks;

  logic                   w_tick;
  logic                   w_wr_ok;
  logic                   w_pre_clr;
  logic                   w_pre_en;
  logic [ENT_W-1:0]       w_entry;
  seq_cmd_e               w_cmd;
  logic [PHASE_WIDTH-1:0] w_value;
  logic [3:0]             w_speed;

`ifdef TRACKER_SEQ_PORTA_EN
  localparam logic [PHASE_WIDTH-1:0] STEP = PHASE_WIDTH'(PORTA_STEP);
  logic [PHASE_WIDTH-1:0] r_target;
`endif

  assign w_wr_ok   = cfg_wr_en && (r_state == IDLE);
  assign w_entry   = r_pattern[r_row_idx];
  assign w_cmd     = seq_cmd_e'(w_entry[ENT_W-1 -: CMD_W]);
  assign w_value   = w_entry[PHASE_WIDTH-1:0];
  assign w_speed   = (speed == 4'd0) ? 4'd1 : speed;
  // Prescaler restarts from zero at every row so each row gets whole ticks.
  assign w_pre_clr = (r_state != PLAY) || start || stop;
  assign w_pre_en  = (r_state == PLAY);

  tracker_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk            (clk),
    .rst_active_high(rst_active_high),
    .clr            (w_pre_clr),
    .en             (w_pre_en),
    .tick           (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      for (int i = 0; i < ROWS; i++) r_pattern[i] <= '0;
    end else if (w_wr_ok) begin
      r_pattern[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      r_state   <= IDLE;
      r_freq    <= '0;
      r_gate    <= 1'b0;
      r_retrig  <= 1'b0;
      r_strobe  <= 1'b0;
      r_row_idx <= '0;
      r_ticks   <= '0;
`ifdef TRACKER_SEQ_PORTA_EN
      r_target  <= '0;
`endif
    end else begin
      r_retrig <= 1'b0;
      r_strobe <= 1'b0;
      if (stop) begin
        r_state   <= IDLE;
        r_gate    <= 1'b0;
        r_row_idx <= '0;
      end else if (start) begin
        r_state   <= FETCH;
        r_row_idx <= '0;
      end else begin
        case (r_state)
          FETCH: begin
            if (w_cmd == END) begin
              // END on row 0 means nothing playable: give up rather than spin.
              if (r_row_idx != '0) begin
                r_row_idx <= '0;
              end else begin
                r_gate  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_strobe <= 1'b1;
              r_ticks  <= w_speed;
              r_state  <= PLAY;
              case (w_cmd)
                NOTE: begin
`ifdef TRACKER_SEQ_PORTA_EN
                  r_target <= w_value;
                  if (!r_gate) begin
                    r_freq   <= w_value;
                    r_retrig <= 1'b1;
                  end
`else
                  r_freq   <= w_value;
                  r_retrig <= 1'b1;
`endif
                  r_gate <= 1'b1;
                end
                REST:    r_gate <= 1'b0;
                default: ;
              endcase
            end
          end
          PLAY: begin
            if (w_tick) begin
              r_ticks <= r_ticks - 4'd1;
              if (r_ticks == 4'd1) begin
                r_row_idx <= r_row_idx + ROW_W'(1);
                r_state   <= FETCH;
              end
`ifdef TRACKER_SEQ_PORTA_EN
              if (r_freq < r_target) begin
                r_freq <= (r_target - r_freq > STEP) ? r_freq + STEP : r_target;
              end else if (r_freq > r_target) begin
                r_freq <= (r_freq - r_target > STEP) ? r_freq - STEP : r_target;
              end
`endif
            end
          end
          IDLE:    ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cfg_wr_ready = (r_state == IDLE);
  assign playing      = (r_state != IDLE);
  assign freq_word    = r_freq;
  assign gate         = r_gate;
  assign dds_retrig   = r_retrig;
  assign row_idx      = r_row_idx;
  assign row_strobe   = r_strobe;

endmodule

// File: tb/tb_tracker_row_sequencer.sv
// Directed bench for tracker_row_sequencer with TICK_DIV=4, ROWS=4.
module tb_tracker_row_sequencer;

  logic       clk = 1'b0;
  logic       rst_active_high;
  logic       start;
  logic       stop;
  logic [3:0] speed;
  logic       cfg_wr_en;
  logic [1:0] cfg_wr_addr;
  logic [11:0] cfg_wr_data;
  logic       cfg_wr_ready;
  logic [9:0] freq_word;
  logic       gate;
  logic       dds_retrig;
  logic [1:0] row_idx;
  logic       row_strobe;
  logic       playing;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  localparam logic [1:0] C_REST = 2'b00;
  localparam logic [1:0] C_NOTE = 2'b01;
  localparam logic [1:0] C_HOLD = 2'b10;
  localparam logic [1:0] C_END  = 2'b11;

  tracker_row_sequencer #(
    .PHASE_WIDTH(10),
    .ROWS       (4),
    .TICK_DIV   (4),
    .PORTA_STEP (4)
  ) dut (
    .clk            (clk),
    .rst_active_high(rst_active_high),
    .start          (start),
    .stop           (stop),
    .speed          (speed),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_ready   (cfg_wr_ready),
    .freq_word      (freq_word),
    .gate           (gate),
    .dds_retrig     (dds_retrig),
    .row_idx        (row_idx),
    .row_strobe     (row_strobe),
    .playing        (playing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] c, input logic [9:0] v);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = {c, v};
    step();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Cycles from now until the next row_strobe; returns the bound on timeout.
  task automatic wait_strobe(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!row_strobe && cnt < 40);
  endtask

  initial begin
    rst_active_high = 1'b1;
    start = 1'b0; stop = 1'b0; speed = 4'd2;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    step(); step();
    rst_active_high = 1'b0;
    chk("rst_freq",   32'(freq_word), 32'h0);
    chk("rst_gate",   32'(gate), 32'h0);
    chk("rst_playing", 32'(playing), 32'h0);
    chk("rst_ready",  32'(cfg_wr_ready), 32'h1);
    chk("rst_row",    32'(row_idx), 32'h0);
    chk("rst_retrig", 32'(dds_retrig), 32'h0);

    // Basic four-row pattern at speed 2: row period 2*4+1 = 9.
    wr(2'd0, C_NOTE, 10'h040);
    wr(2'd1, C_HOLD, 10'h000);
    wr(2'd2, C_REST, 10'h000);
    wr(2'd3, C_NOTE, 10'h080);
    pulse_start();
    chk("fetch_gate",  32'(gate), 32'h0);
    chk("fetch_play",  32'(playing), 32'h1);
    step();
    chk("r0_freq",   32'(freq_word), 32'h040);
    chk("r0_gate",   32'(gate), 32'h1);
    chk("r0_retrig", 32'(dds_retrig), 32'h1);
    chk("r0_strobe", 32'(row_strobe), 32'h1);
    step();
    chk("r0_retrig2", 32'(dds_retrig), 32'h0);
    wait_strobe(n);
    chk("r1_period", 32'(n + 1), 32'd9);
    chk("r1_row",    32'(row_idx), 32'd1);
    chk("r1_gate",   32'(gate), 32'h1);
    chk("r1_retrig", 32'(dds_retrig), 32'h0);
    wait_strobe(n);
    chk("r2_period", 32'(n), 32'd9);
    chk("r2_gate",   32'(gate), 32'h0);
    chk("r2_freq",   32'(freq_word), 32'h040);
    chk("r2_retrig", 32'(dds_retrig), 32'h0);
    wait_strobe(n);
    chk("r3_period", 32'(n), 32'd9);
    chk("r3_freq",   32'(freq_word), 32'h080);
    chk("r3_retrig", 32'(dds_retrig), 32'h1);
    wait_strobe(n);
    chk("wrap_period", 32'(n), 32'd9);
    chk("wrap_row",    32'(row_idx), 32'd0);
`ifndef TRACKER_SEQ_PORTA_EN
    chk("wrap_freq",   32'(freq_word), 32'h040);
    chk("wrap_retrig", 32'(dds_retrig), 32'h1);
`endif

    // Write during PLAY is dropped; stop beats simultaneous start.
    chk("play_ready", 32'(cfg_wr_ready), 32'h0);
    wr(2'd2, C_NOTE, 10'h1FF);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_playing", 32'(playing), 32'h0);
    chk("ss_gate",    32'(gate), 32'h0);
    chk("ss_row",     32'(row_idx), 32'h0);
`ifndef TRACKER_SEQ_PORTA_EN
    chk("ss_freq",    32'(freq_word), 32'h040);
`endif
    pulse_start();
    step();
    wait_strobe(n);
    wait_strobe(n);
    chk("rb_row",  32'(row_idx), 32'd2);
    chk("rb_gate", 32'(gate), 32'h0);
    chk("rb_freq", 32'(freq_word), 32'h040);
    pulse_stop();

    // END at row 1 loops to row 0 with an extra strobe-less FETCH cycle.
    wr(2'd1, C_END, 10'h000);
    pulse_start();
    step();
    wait_strobe(n);
    chk("end_period", 32'(n), 32'd10);
    chk("end_row",    32'(row_idx), 32'd0);
    chk("end_freq",   32'(freq_word), 32'h040);
    pulse_stop();

    // Empty pattern (END at row 0) drops straight back to IDLE.
    wr(2'd0, C_END, 10'h000);
    wr(2'd2, C_END, 10'h000);
    wr(2'd3, C_END, 10'h000);
    pulse_start();
    chk("empty_fetch", 32'(playing), 32'h1);
    step();
    chk("empty_playing", 32'(playing), 32'h0);
    chk("empty_strobe",  32'(row_strobe), 32'h0);
    chk("empty_ready",   32'(cfg_wr_ready), 32'h1);

    // speed 0 behaves as speed 1: period 1*4+1 = 5.
    wr(2'd0, C_NOTE, 10'h100);
    wr(2'd1, C_HOLD, 10'h000);
    wr(2'd2, C_HOLD, 10'h000);
    wr(2'd3, C_HOLD, 10'h000);
    speed = 4'd0;
    pulse_start();
    step();
    chk("s0_freq", 32'(freq_word), 32'h100);
    wait_strobe(n);
    chk("s0_period", 32'(n), 32'd5);
    speed = 4'd1;
    wait_strobe(n);
    chk("s0_period2", 32'(n), 32'd5);
    wait_strobe(n);
    chk("s1_period", 32'(n), 32'd5);

    // Reset mid-row clears outputs and the pattern.
    step(); step();
    rst_active_high = 1'b1;
    step();
    rst_active_high = 1'b0;
    chk("mrst_freq",    32'(freq_word), 32'h0);
    chk("mrst_gate",    32'(gate), 32'h0);
    chk("mrst_playing", 32'(playing), 32'h0);
    chk("mrst_ready",   32'(cfg_wr_ready), 32'h1);
    chk("mrst_row",     32'(row_idx), 32'h0);
    pulse_start();
    step();
    chk("clr_strobe", 32'(row_strobe), 32'h1);
    chk("clr_gate",   32'(gate), 32'h0);
    chk("clr_retrig", 32'(dds_retrig), 32'h0);
    chk("clr_freq",   32'(freq_word), 32'h0);
    pulse_stop();

`ifdef TRACKER_SEQ_PORTA_EN
    // Glide 0x040 -> 0x04A in steps of 4 per tick, one retrigger only.
    wr(2'd0, C_NOTE, 10'h040);
    wr(2'd1, C_NOTE, 10'h04A);
    speed = 4'd4;
    pulse_start();
    step();
    chk("pa_freq0",   32'(freq_word), 32'h040);
    chk("pa_retrig0", 32'(dds_retrig), 32'h1);
    wait_strobe(n);
    chk("pa_period",  32'(n), 32'd17);
    chk("pa_freq1",   32'(freq_word), 32'h040);
    chk("pa_retrig1", 32'(dds_retrig), 32'h0);
    repeat (4) step();
    chk("pa_t1", 32'(freq_word), 32'h044);
    repeat (4) step();
    chk("pa_t2", 32'(freq_word), 32'h048);
    repeat (4) step();
    chk("pa_t3", 32'(freq_word), 32'h04A);
    chk("pa_gate", 32'(gate), 32'h1);
    pulse_stop();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
